// File: rtl/life_run_ctrl.sv
// Run sequencer for the conway_life grid: LOAD/RUN/STEP/CLEAR commands, generation counting, halt detection.
// Optional period-2 oscillator halt is compiled in with `define LIFE_P2_DET_EN.
module life_run_ctrl #(
  parameter int WIDTH     = 16,
  parameter int HEIGHT    = 16,
  parameter int FULLWIDTH = WIDTH * HEIGHT,
  parameter int GEN_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [FULLWIDTH-1:0] cmd_pattern,
  input  logic [GEN_W-1:0]     cmd_gens,
  input  logic                 abort,
  output logic                 grid_load,
  output logic [FULLWIDTH-1:0] grid_data,
  input  logic [FULLWIDTH-1:0] grid_q,
  output logic                 busy,
  output logic [GEN_W-1:0]     gen_cnt,
  output logic                 done_pulse,
  output logic [2:0]           halt_reason
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STEP} state_e;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [2:0] HR_NONE    = 3'd0;
  localparam logic [2:0] HR_COUNT   = 3'd1;
  localparam logic [2:0] HR_EXTINCT = 3'd2;
  localparam logic [2:0] HR_STILL   = 3'd3;
  localparam logic [2:0] HR_ABORT   = 3'd4;
`ifdef LIFE_P2_DET_EN
  localparam logic [2:0] HR_PERIOD2 = 3'd5;
`endif

  state_e                 state_q, state_d;
  logic [GEN_W-1:0]       gen_cnt_q, gen_cnt_d;
  logic [GEN_W-1:0]       target_q, target_d;
  logic [2:0]             halt_reason_q, halt_reason_d;
  logic                   done_pulse_q, done_pulse_d;
  logic                   prev_valid_q, prev_valid_d;
  logic [FULLWIDTH-1:0]   prev_q, prev_d;
`ifdef LIFE_P2_DET_EN
  logic [FULLWIDTH-1:0]   prev2_q, prev2_d;
  logic [1:0]             p2_cnt_q, p2_cnt_d;
`endif

  logic                   advance;
  logic                   halt;
  logic [2:0]             halt_code;

  function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
    return (&v) ? v : v + {{(GEN_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_d       = state_q;
    gen_cnt_d     = gen_cnt_q;
    target_d      = target_q;
    halt_reason_d = halt_reason_q;
    done_pulse_d  = 1'b0;
    prev_valid_d  = prev_valid_q;
    prev_d        = prev_q;
`ifdef LIFE_P2_DET_EN
    prev2_d       = prev2_q;
    p2_cnt_d      = p2_cnt_q;
`endif
    grid_load     = 1'b1;
    grid_data     = grid_q;
    advance       = 1'b0;
    halt          = 1'b0;
    halt_code     = HR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && rst_n) begin
          gen_cnt_d     = '0;
          halt_reason_d = HR_NONE;
          case (cmd_op)
            OP_LOAD, OP_CLEAR: begin
              grid_data    = (cmd_op == OP_LOAD) ? cmd_pattern : '0;
              prev_valid_d = 1'b0;
`ifdef LIFE_P2_DET_EN
              p2_cnt_d     = 2'd0;
`endif
            end
            OP_RUN: begin
              target_d = cmd_gens;
              state_d  = ST_RUN;
            end
            OP_STEP: state_d = ST_STEP;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        halt = 1'b1;
        if (abort)                                          halt_code = HR_ABORT;
        else if ((target_q != '0) && (gen_cnt_q == target_q)) halt_code = HR_COUNT;
        else if (grid_q == '0)                              halt_code = HR_EXTINCT;
        else if (prev_valid_q && (grid_q == prev_q))        halt_code = HR_STILL;
`ifdef LIFE_P2_DET_EN
        else if ((p2_cnt_q == 2'd2) && (grid_q == prev2_q)) halt_code = HR_PERIOD2;
`endif
        else begin
          halt    = 1'b0;
          advance = 1'b1;
        end
      end
      ST_STEP: begin
        // A step is one unconditional advance followed by a COUNT halt.
        halt = 1'b1;
        if (abort)                  halt_code = HR_ABORT;
        else if (gen_cnt_q != '0)   halt_code = HR_COUNT;
        else begin
          halt    = 1'b0;
          advance = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      grid_load    = 1'b0;
      gen_cnt_d    = sat_inc(gen_cnt_q);
      prev_d       = grid_q;
      prev_valid_d = 1'b1;
`ifdef LIFE_P2_DET_EN
      prev2_d      = prev_q;
      p2_cnt_d     = (p2_cnt_q == 2'd2) ? 2'd2 : p2_cnt_q + 2'd1;
`endif
    end

    if (halt) begin
      halt_reason_d = halt_code;
      state_d       = ST_IDLE;
      done_pulse_d  = 1'b1;
    end

    // Keep the grid frozen while reset is asserted, whatever the host drives.
    if (!rst_n) begin
      grid_load = 1'b1;
      grid_data = grid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      gen_cnt_q     <= '0;
      target_q      <= '0;
      halt_reason_q <= HR_NONE;
      done_pulse_q  <= 1'b0;
      prev_valid_q  <= 1'b0;
`ifdef LIFE_P2_DET_EN
      p2_cnt_q      <= 2'd0;
`endif
    end else begin
      state_q       <= state_d;
      gen_cnt_q     <= gen_cnt_d;
      target_q      <= target_d;
      halt_reason_q <= halt_reason_d;
      done_pulse_q  <= done_pulse_d;
      prev_valid_q  <= prev_valid_d;
`ifdef LIFE_P2_DET_EN
      p2_cnt_q      <= p2_cnt_d;
`endif
    end
  end

  // History images are qualified by prev_valid/p2_cnt, so they need no reset.
  always_ff @(posedge clk) begin
    prev_q  <= prev_d;
`ifdef LIFE_P2_DET_EN
    prev2_q <= prev2_d;
`endif
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign gen_cnt     = gen_cnt_q;
  assign done_pulse  = done_pulse_q;
  assign halt_reason = halt_reason_q;

endmodule

// File: tb/tb_life_run_ctrl.sv
// Directed bench for life_run_ctrl; a behavioural torus Life grid stands in for conway_life.
module tb_life_run_ctrl;
  localparam int W  = 16;
  localparam int H  = 16;
  localparam int FW = W * H;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [FW-1:0] cmd_pattern;
  logic [GW-1:0] cmd_gens;
  logic          abort;
  logic          grid_load;
  logic [FW-1:0] grid_data;
  logic [FW-1:0] gq;
  logic          busy;
  logic [GW-1:0] gen_cnt;
  logic          done_pulse;
  logic [2:0]    halt_reason;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [FW-1:0] pat_cell, pat_block, pat_blinker, pat_glider, pat_glider1;

  always #5 clk = ~clk;

  life_run_ctrl #(.WIDTH(W), .HEIGHT(H), .FULLWIDTH(FW), .GEN_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_pattern(cmd_pattern), .cmd_gens(cmd_gens), .abort(abort),
    .grid_load(grid_load), .grid_data(grid_data), .grid_q(gq), .busy(busy),
    .gen_cnt(gen_cnt), .done_pulse(done_pulse), .halt_reason(halt_reason)
  );

  function automatic logic [FW-1:0] life_next(input logic [FW-1:0] g);
    logic [FW-1:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0))
              cnt += int'(g[((r + dr + H) % H) * W + ((c + dc + W) % W)]);
        n[r*W+c] = (cnt == 3) || (cnt == 2 && g[r*W+c]);
      end
    end
    return n;
  endfunction

  always @(posedge clk) gq <= grid_load ? grid_data : life_next(gq);

  function automatic logic [FW-1:0] put(input logic [FW-1:0] g, input int r, input int c);
    g[r*W+c] = 1'b1;
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [FW-1:0] pat, input logic [GW-1:0] gens);
    cmd_op = op; cmd_pattern = pat; cmd_gens = gens; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int ticks);
    ticks = 0;
    while (!done_pulse && ticks < limit) begin
      tick();
      ticks++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_op = 2'd0; cmd_pattern = '0; cmd_gens = '0;
    gq = '0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (gen_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_gen_cnt: got %0d want 0", gen_cnt); end
    n_cmp++; if (halt_reason !== 3'd0) begin n_fail++; $display("FAIL reset_halt: got %0d want 0", halt_reason); end
    n_cmp++; if (done_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done_pulse); end
    n_cmp++; if (grid_load !== 1'b1) begin n_fail++; $display("FAIL reset_grid_load: got %0b want 1", grid_load); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %0b want 1", cmd_ready); end
  endtask

  task automatic test_load_clear();
    int t;
    abort = 1'b1;
    cmd_op = 2'd0; cmd_pattern = pat_block; cmd_valid = 1'b1;
    #1;
    n_cmp++; if (grid_load !== 1'b1 || grid_data !== pat_block) begin n_fail++;
      $display("FAIL load_comb: load=%0b data_ok=%0b want load=1 data=pattern", grid_load, grid_data === pat_block); end
    tick();
    cmd_valid = 1'b0; abort = 1'b0;
    n_cmp++; if (gq !== pat_block) begin n_fail++; $display("FAIL load_grid: got %h want %h", gq, pat_block); end
    n_cmp++; if (busy !== 1'b0 || done_pulse !== 1'b0 || gen_cnt !== 16'd0) begin n_fail++;
      $display("FAIL load_state: busy=%0b done=%0b gen=%0d want 0/0/0", busy, done_pulse, gen_cnt); end
    cmd_op = 2'd3; cmd_valid = 1'b1;
    #1;
    n_cmp++; if (grid_data !== '0) begin n_fail++; $display("FAIL clear_comb: got %h want 0", grid_data); end
    tick();
    cmd_valid = 1'b0;
    n_cmp++; if (gq !== '0) begin n_fail++; $display("FAIL clear_grid: got %h want 0", gq); end
    send_cmd(2'd1, '0, 16'd0);
    wait_done(10, t);
    n_cmp++; if (t !== 1 || halt_reason !== 3'd2 || gen_cnt !== 16'd0) begin n_fail++;
      $display("FAIL empty_run: ticks=%0d halt=%0d gen=%0d want 1/2/0", t, halt_reason, gen_cnt); end
    tick();
  endtask

  task automatic test_extinct();
    int t;
    send_cmd(2'd0, pat_cell, '0);
    send_cmd(2'd1, '0, 16'd0);
    wait_done(20, t);
    n_cmp++; if (t !== 2) begin n_fail++; $display("FAIL extinct_latency: got %0d want 2", t); end
    n_cmp++; if (halt_reason !== 3'd2 || gen_cnt !== 16'd1) begin n_fail++;
      $display("FAIL extinct_result: halt=%0d gen=%0d want 2/1", halt_reason, gen_cnt); end
    n_cmp++; if (gq !== '0 || cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL extinct_grid: grid_zero=%0b ready=%0b want 1/1", gq === '0, cmd_ready); end
    tick();
    n_cmp++; if (done_pulse !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %0b want 0", done_pulse); end
  endtask

  task automatic test_still();
    int t;
    send_cmd(2'd0, pat_block, '0);
    send_cmd(2'd1, '0, 16'd0);
    wait_done(20, t);
    n_cmp++; if (t !== 2 || halt_reason !== 3'd3 || gen_cnt !== 16'd1) begin n_fail++;
      $display("FAIL still_result: ticks=%0d halt=%0d gen=%0d want 2/3/1", t, halt_reason, gen_cnt); end
    n_cmp++; if (gq !== pat_block) begin n_fail++; $display("FAIL still_grid: got %h want %h", gq, pat_block); end
    tick();
  endtask

  task automatic test_blinker();
    int t;
    send_cmd(2'd0, pat_blinker, '0);
    send_cmd(2'd1, '0, 16'd4);
    wait_done(20, t);
`ifdef LIFE_P2_DET_EN
    n_cmp++; if (t !== 3 || halt_reason !== 3'd5 || gen_cnt !== 16'd2) begin n_fail++;
      $display("FAIL blinker_p2: ticks=%0d halt=%0d gen=%0d want 3/5/2", t, halt_reason, gen_cnt); end
    tick();
    send_cmd(2'd0, pat_blinker, '0);
    send_cmd(2'd1, '0, 16'd0);
    wait_done(20, t);
    n_cmp++; if (t !== 3 || halt_reason !== 3'd5 || gen_cnt !== 16'd2) begin n_fail++;
      $display("FAIL blinker_p2_unlimited: ticks=%0d halt=%0d gen=%0d want 3/5/2", t, halt_reason, gen_cnt); end
`else
    n_cmp++; if (t !== 5 || halt_reason !== 3'd1 || gen_cnt !== 16'd4) begin n_fail++;
      $display("FAIL blinker_count: ticks=%0d halt=%0d gen=%0d want 5/1/4", t, halt_reason, gen_cnt); end
`endif
    n_cmp++; if (gq !== pat_blinker) begin n_fail++; $display("FAIL blinker_grid: got %h want %h", gq, pat_blinker); end
    tick();
  endtask

  task automatic test_glider_step();
    int t;
    send_cmd(2'd0, pat_glider, '0);
    send_cmd(2'd1, '0, 16'd64);
    wait_done(100, t);
    n_cmp++; if (t !== 65 || halt_reason !== 3'd1 || gen_cnt !== 16'd64) begin n_fail++;
      $display("FAIL glider64: ticks=%0d halt=%0d gen=%0d want 65/1/64", t, halt_reason, gen_cnt); end
    n_cmp++; if (gq !== pat_glider) begin n_fail++; $display("FAIL glider64_grid: got %h want %h", gq, pat_glider); end
    // Back-to-back: issue STEP in the done_pulse cycle.
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %0b want 1", cmd_ready); end
    send_cmd(2'd2, '0, '0);
    wait_done(10, t);
    n_cmp++; if (t !== 2 || halt_reason !== 3'd1 || gen_cnt !== 16'd1) begin n_fail++;
      $display("FAIL step_result: ticks=%0d halt=%0d gen=%0d want 2/1/1", t, halt_reason, gen_cnt); end
    n_cmp++; if (gq !== pat_glider1) begin n_fail++; $display("FAIL step_grid: got %h want %h", gq, pat_glider1); end
    tick();
    send_cmd(2'd0, pat_glider, '0);
    send_cmd(2'd2, '0, '0);
    abort = 1'b1;
    wait_done(10, t);
    abort = 1'b0;
    n_cmp++; if (t !== 1 || halt_reason !== 3'd4 || gen_cnt !== 16'd0) begin n_fail++;
      $display("FAIL step_abort: ticks=%0d halt=%0d gen=%0d want 1/4/0", t, halt_reason, gen_cnt); end
    n_cmp++; if (gq !== pat_glider) begin n_fail++; $display("FAIL step_abort_grid: got %h want %h", gq, pat_glider); end
    tick();
  endtask

  task automatic test_abort();
    int t;
    logic [FW-1:0] snap;
    logic bad;
    send_cmd(2'd0, pat_glider, '0);
    send_cmd(2'd1, '0, 16'd0);
    repeat (4) tick();
    cmd_op = 2'd3; cmd_valid = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0 || grid_load !== 1'b0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL busy_ignore: ready=%0b load=%0b busy=%0b want 0/0/1", cmd_ready, grid_load, busy); end
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    wait_done(10, t);
    n_cmp++; if (t !== 1 || halt_reason !== 3'd4 || gen_cnt !== 16'd9) begin n_fail++;
      $display("FAIL abort_result: ticks=%0d halt=%0d gen=%0d want 1/4/9", t, halt_reason, gen_cnt); end
    snap = gq; bad = 1'b0;
    repeat (20) begin
      tick();
      if (gq !== snap || grid_load !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    abort = 1'b0;
    n_cmp++; if (bad !== 1'b0 || snap === '0) begin n_fail++;
      $display("FAIL abort_hold: changed=%0b empty=%0b want 0/0", bad, snap === '0); end
  endtask

  task automatic test_reset_mid_run();
    logic [FW-1:0] snap;
    send_cmd(2'd0, pat_glider, '0);
    send_cmd(2'd1, '0, 16'd0);
    repeat (5) tick();
    rst_n = 1'b0;
    cmd_op = 2'd0; cmd_pattern = '1; cmd_valid = 1'b1;
    #1;
    snap = gq;
    n_cmp++; if (busy !== 1'b0 || gen_cnt !== 16'd0 || halt_reason !== 3'd0) begin n_fail++;
      $display("FAIL midrst_state: busy=%0b gen=%0d halt=%0d want 0/0/0", busy, gen_cnt, halt_reason); end
    n_cmp++; if (grid_load !== 1'b1 || grid_data !== gq) begin n_fail++;
      $display("FAIL midrst_grid_out: load=%0b data_is_q=%0b want 1/1", grid_load, grid_data === gq); end
    repeat (3) tick();
    n_cmp++; if (gq !== snap) begin n_fail++; $display("FAIL midrst_hold: got %h want %h", gq, snap); end
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++; if (gq !== snap || busy !== 1'b0) begin n_fail++;
      $display("FAIL postrst_hold: grid_same=%0b busy=%0b want 1/0", gq === snap, busy); end
  endtask

  initial begin
    pat_cell    = put('0, 8, 8);
    pat_block   = put(put(put(put('0, 4, 4), 4, 5), 5, 4), 5, 5);
    pat_blinker = put(put(put('0, 8, 7), 8, 8), 8, 9);
    pat_glider  = put(put(put(put(put('0, 1, 2), 2, 3), 3, 1), 3, 2), 3, 3);
    pat_glider1 = put(put(put(put(put('0, 2, 1), 2, 3), 3, 2), 3, 3), 4, 2);
    test_reset();
    test_load_clear();
    test_extinct();
    test_still();
    test_blinker();
    test_glider_step();
    test_abort();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
